// File: rtl/lf_ssp_tx.sv
// LF sample serializer toward the ARM SSP port: a small sample FIFO feeding an
// MSB-first shifter with generated ssp_clk and a one-bit-period frame marker.
module lf_ssp_tx #(
  parameter int unsigned HALF_PERIOD = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       pck0,
  input  logic       nrst,
  input  logic [7:0] sample_d,
  input  logic       sample_valid,
  output logic       sample_ready,
  input  logic       enable,
  input  logic       ovf_clr,
  output logic       ssp_clk,
  output logic       ssp_frame,
  output logic       ssp_din,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] EMPTY_CNT = {CNT_W{1'b0}};
  localparam logic [7:0]       HALF_LAST = 8'(HALF_PERIOD - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r, count_n;
  logic             push_s, drop_s, pop_s, have_data_s;

  state_t     state_r, state_n;
  logic [7:0] half_r, half_n;
  logic       phase_r, phase_n;
  logic [2:0] bit_r, bit_n;
  logic [7:0] shift_r, shift_n;

  // FIFO push/drop decode and occupancy update
  always_comb begin
    push_s      = sample_valid && (count_r != FULL_CNT);
    drop_s      = sample_valid && (count_r == FULL_CNT);
    have_data_s = (count_r != EMPTY_CNT);
    if (push_s && !pop_s) begin
      count_n = count_r + CNT_W'(1);
    end else if (pop_s && !push_s) begin
      count_n = count_r - CNT_W'(1);
    end else begin
      count_n = count_r;
    end
  end

  // FIFO storage, pointers and count
  always_ff @(posedge pck0 or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 8'h00;
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= EMPTY_CNT;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= sample_d;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_n;
    end
  end

  // Shifter FSM: a bit period is a low half then a high half of HALF_PERIOD cycles
  always_comb begin
    state_n = state_r;
    half_n  = half_r;
    phase_n = phase_r;
    bit_n   = bit_r;
    shift_n = shift_r;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable && have_data_s) begin
          pop_s   = 1'b1;
          shift_n = mem_r[rd_ptr_r];
          half_n  = 8'd0;
          phase_n = 1'b0;
          bit_n   = 3'd0;
          state_n = SHIFT;
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        if (half_r != HALF_LAST) begin
          half_n = half_r + 8'd1;
        end else if (!phase_r) begin
          half_n  = 8'd0;
          phase_n = 1'b1;
        end else begin
          half_n  = 8'd0;
          phase_n = 1'b0;
          if (bit_r != 3'd7) begin
            bit_n   = bit_r + 3'd1;
            shift_n = {shift_r[6:0], 1'b0};
          end else if (enable && have_data_s) begin
            // next byte follows with no gap cycle
            pop_s   = 1'b1;
            shift_n = mem_r[rd_ptr_r];
            bit_n   = 3'd0;
          end else begin
            bit_n   = 3'd0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge pck0 or negedge nrst) begin
    if (!nrst) begin
      state_r <= IDLE;
      half_r  <= 8'd0;
      phase_r <= 1'b0;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
    end else begin
      state_r <= state_n;
      half_r  <= half_n;
      phase_r <= phase_n;
      bit_r   <= bit_n;
      shift_r <= shift_n;
    end
  end

  // Registered outputs, derived from next state so they align with the state registers
  always_ff @(posedge pck0 or negedge nrst) begin
    if (!nrst) begin
      ssp_clk      <= 1'b0;
      ssp_frame    <= 1'b0;
      ssp_din      <= 1'b0;
      busy         <= 1'b0;
      sample_ready <= 1'b1;
      overflow     <= 1'b0;
    end else begin
      ssp_clk      <= (state_n == SHIFT) && phase_n;
      ssp_frame    <= (state_n == SHIFT) && (bit_n == 3'd0);
      ssp_din      <= (state_n == SHIFT) && shift_n[7];
      busy         <= (state_n == SHIFT);
      sample_ready <= (count_n != FULL_CNT);
      if (drop_s) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end else begin
        overflow <= overflow;
      end
    end
  end

endmodule

// File: tb/tb_lf_ssp_tx.sv
// Directed bench for lf_ssp_tx: one instance with HALF_PERIOD=2 and one with
// HALF_PERIOD=1, both FIFO_DEPTH=4, expected waveforms computed from byte values.
module tb_lf_ssp_tx;

  logic       pck0 = 1'b0;
  logic       nrst = 1'b1;
  logic [7:0] sample_d = 8'h00;
  logic       sample_valid = 1'b0;
  logic       enable = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       sample_ready, ssp_clk, ssp_frame, ssp_din, busy, overflow;

  logic [7:0] d1 = 8'h00;
  logic       v1 = 1'b0;
  logic       en1 = 1'b0;
  logic       rdy1, clk1, frm1, din1, busy1, ovf1;

  int errors = 0;
  int checks = 0;

  always #5 pck0 = ~pck0;

  lf_ssp_tx #(.HALF_PERIOD(2), .FIFO_DEPTH(4)) dut (
    .pck0(pck0), .nrst(nrst), .sample_d(sample_d), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .enable(enable), .ovf_clr(ovf_clr),
    .ssp_clk(ssp_clk), .ssp_frame(ssp_frame), .ssp_din(ssp_din),
    .busy(busy), .overflow(overflow)
  );

  lf_ssp_tx #(.HALF_PERIOD(1), .FIFO_DEPTH(4)) dut1 (
    .pck0(pck0), .nrst(nrst), .sample_d(d1), .sample_valid(v1),
    .sample_ready(rdy1), .enable(en1), .ovf_clr(1'b0),
    .ssp_clk(clk1), .ssp_frame(frm1), .ssp_din(din1),
    .busy(busy1), .overflow(ovf1)
  );

  task automatic step();
    @(posedge pck0);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_clk"}, ssp_clk, 0);
    chk({tag, "_frame"}, ssp_frame, 0);
    chk({tag, "_din"}, ssp_din, 0);
  endtask

  // Called at cycle 'start' of a byte on dut (cycle 0 = just after the pop edge);
  // with HALF_PERIOD=2 each bit spans 4 cycles, clk high in the last 2.
  task automatic expect_byte(input logic [7:0] b, input int start, input int drop_en_at);
    int   rises;
    logic prev;
    rises = 0;
    prev  = 1'b0;
    for (int k = start; k < 32; k++) begin
      if (k > start && ssp_clk && !prev) rises++;
      prev = ssp_clk;
      chk($sformatf("busy_%h_k%0d", b, k), busy, 1);
      chk($sformatf("clk_%h_k%0d", b, k), ssp_clk, ((k % 4) >= 2));
      chk($sformatf("din_%h_k%0d", b, k), ssp_din, b[7 - k / 4]);
      chk($sformatf("frame_%h_k%0d", b, k), ssp_frame, (k < 4));
      if (k == drop_en_at) enable = 1'b0;
      step();
    end
    if (start == 0) chk($sformatf("clk_rises_%h", b), rises, 8);
  endtask

  initial begin
    // reset from idle, checked before any clock edge
    #2 nrst = 1'b0;
    #1;
    idle_chk("rst0");
    chk("rst0_ready", sample_ready, 1);
    chk("rst0_ovf", overflow, 0);
    chk("rst0_busy1", busy1, 0);
    @(negedge pck0);
    nrst   = 1'b1;
    enable = 1'b1;
    en1    = 1'b1;
    step();

    // single byte 0xA5
    sample_d = 8'hA5; sample_valid = 1'b1;
    step();
    chk("a5_e0_busy", busy, 0);
    chk("a5_e0_frame", ssp_frame, 0);
    sample_valid = 1'b0;
    step();
    expect_byte(8'hA5, 0, -1);
    idle_chk("a5_end");

    // back-to-back 0x00 then 0xFF
    sample_d = 8'h00; sample_valid = 1'b1;
    step();
    sample_d = 8'hFF;
    step();
    sample_valid = 1'b0;
    expect_byte(8'h00, 0, -1);
    expect_byte(8'hFF, 0, -1);
    idle_chk("b2b_end");

    // overflow: 0x01 pops immediately, 0x02..0x05 fill the FIFO, 0x06 drops
    sample_d = 8'h01; sample_valid = 1'b1;
    step();
    sample_d = 8'h02; step();
    sample_d = 8'h03; step();
    sample_d = 8'h04; step();
    sample_d = 8'h05; step();
    chk("ovf_ready_full", sample_ready, 0);
    chk("ovf_not_yet", overflow, 0);
    sample_d = 8'h06; ovf_clr = 1'b1;
    step();
    sample_valid = 1'b0; ovf_clr = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    chk("ovf_ready_still_full", sample_ready, 0);
    expect_byte(8'h01, 4, -1);
    expect_byte(8'h02, 0, -1);
    expect_byte(8'h03, 0, -1);
    expect_byte(8'h04, 0, -1);
    expect_byte(8'h05, 0, -1);
    idle_chk("ovf_end");
    chk("ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);
    chk("ovf_ready_empty", sample_ready, 1);

    // enable gating: drop enable in bit 3 of 0x3C, 0xC3 must wait
    sample_d = 8'h3C; sample_valid = 1'b1;
    step();
    sample_d = 8'hC3;
    step();
    sample_valid = 1'b0;
    expect_byte(8'h3C, 0, 12);
    idle_chk("gate_end");
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("gate_hold_busy_%0d", i), busy, 0);
    end
    chk("gate_ready_held", sample_ready, 1);
    enable = 1'b1;
    step();
    expect_byte(8'hC3, 0, -1);
    idle_chk("gate_c3_end");

    // HALF_PERIOD=1: 0x80 on dut1, clk toggles every cycle
    d1 = 8'h80; v1 = 1'b1;
    step();
    v1 = 1'b0;
    step();
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("hp1_clk_k%0d", k), clk1, (k % 2));
      chk($sformatf("hp1_din_k%0d", k), din1, (k < 2));
      chk($sformatf("hp1_frame_k%0d", k), frm1, (k < 2));
      chk($sformatf("hp1_busy_k%0d", k), busy1, 1);
      step();
    end
    chk("hp1_end_busy", busy1, 0);
    chk("hp1_end_clk", clk1, 0);

    // mid-byte reset with overflow set and FIFO loaded while disabled
    enable = 1'b0;
    sample_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample_d = 8'(8'h10 + i);
      step();
    end
    sample_valid = 1'b0;
    chk("mr_ovf_set", overflow, 1);
    chk("mr_ready_full", sample_ready, 0);
    chk("mr_no_start", busy, 0);
    enable = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("mr_busy_before", busy, 1);
    #2 nrst = 1'b0;
    #1;
    idle_chk("mr_rst");
    chk("mr_rst_ovf", overflow, 0);
    chk("mr_rst_ready", sample_ready, 1);
    @(negedge pck0);
    nrst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      chk($sformatf("mr_after_busy_%0d", i), busy, 0);
    end
    chk("mr_after_frame", ssp_frame, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lf_ssp_tx.md
# lf_ssp_tx

FPGA-to-ARM SSP serializer for the LF bitstream. It accepts 8-bit samples from an LF mode (for example the ADC sample from the LF reader) through a small FIFO. It sends each sample MSB-first on ssp_din, with a generated ssp_clk and a one-bit ssp_frame marker per byte. This is the outbound counterpart of the ncs/spck/mosi configuration receiver: the ARM writes config over SPI, and this block returns data over SSP.

## Interface
Parameters:
- HALF_PERIOD, 2: pck0 cycles per ssp_clk half period; legal range 1..255.
- FIFO_DEPTH, 4: sample FIFO entries; power of two, minimum 2.

Ports:
- pck0  in  1  clock; one clock, all logic on its rising edge.
- nrst  in  1  reset; asynchronous, active-low.
- sample_d  in  8  sample to transmit.
- sample_valid  in  1  push request; a push is accepted when sample_ready=1 in the same cycle.
- sample_ready  out  1  FIFO not full.
- enable  in  1  allows a new byte to start.
- ovf_clr  in  1  clears overflow.
- ssp_clk  out  1  serial clock to the ARM; the ARM samples on the rising edge.
- ssp_frame  out  1  high during the MSB bit period of each byte.
- ssp_din  out  1  serial data, MSB first.
- busy  out  1  a byte is being shifted.
- overflow  out  1  sticky flag; a push was dropped.

## Operation
- FIFO:
  - Uses registered read and write pointers and a count.
  - sample_ready = (count != FIFO_DEPTH), computed from the current count.
  - A push while full is dropped and sets overflow, even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full leaves count unchanged.
- overflow is cleared by ovf_clr. If set and clear occur in the same cycle, set wins.
- The FSM has two states, IDLE and SHIFT.
- IDLE:
  - Outputs: ssp_clk=0, ssp_frame=0, ssp_din=0, busy=0.
  - If enable=1 and count!=0: pop the FIFO head into an 8-bit shifter, clear the half-period counter and bit index, and go to SHIFT.
- SHIFT:
  - Each bit period is 2*HALF_PERIOD cycles.
  - ssp_clk is 0 for the first HALF_PERIOD cycles of the bit period and 1 for the second HALF_PERIOD cycles.
  - ssp_din = shifter[7] for the whole bit period. The shifter shifts left at the end of each bit period.
  - ssp_frame = 1 only during bit index 0 (the MSB).
  - busy = 1.
- At the last cycle of bit 7 (the LSB):
  - If enable=1 and count!=0: pop the next sample and stay in SHIFT at bit 0, with no gap cycle.
  - Otherwise go to IDLE.
- If enable is deasserted mid-byte, the current byte still completes. No new byte starts, and the FIFO contents are retained.
- Counter widths: half counter 8 bits, bit index 3 bits, count $clog2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values, applied asynchronously and immediately on nrst=0:
  - FIFO empty, state IDLE.
  - ssp_clk=0, ssp_frame=0, ssp_din=0, busy=0, overflow=0.
  - sample_ready=1.
- Latency from an idle, empty FIFO:
  - The push is sampled at edge E0; count becomes 1 after E0.
  - The pop occurs at edge E1.
  - ssp_frame, busy and the MSB on ssp_din are valid after E1.
- One byte occupies 16*HALF_PERIOD cycles.
- ssp_clk rising edges occur at the middle of each bit period. Data is stable HALF_PERIOD cycles before and after each rising edge.
- With back-to-back bytes, ssp_frame of byte n+1 rises exactly 16*HALF_PERIOD cycles after that of byte n.
- Reset asserted mid-byte forces reset values at once. The partial byte is lost, and no completion of it is allowed after release.

## Test plan
- **Reset:** assert nrst=0 mid-idle and mid-byte. Required: all outputs take their reset values within the same cycle, sample_ready=1, overflow=0.
- **Single byte:** HALF_PERIOD=2, push 0xA5 once.
  - ssp_frame high for exactly 4 cycles starting 2 edges after the push.
  - ssp_din bit sequence 1,0,1,0,0,1,0,1, each held for 4 cycles.
  - 8 ssp_clk rising edges.
  - busy high for 32 cycles, then IDLE with all outputs 0.
- **Back-to-back:** push 0x00 then 0xFF on consecutive cycles.
  - Two frames 32 cycles apart, no idle cycle between them.
  - ssp_din is 0 for 32 cycles, then 1 for 32 cycles.
- **Overflow:** FIFO_DEPTH=4, push 0x01..0x06 on six consecutive cycles.
  - 0x06 is dropped; overflow=1 and sample_ready=0 in that cycle.
  - Transmitted bytes are 0x01..0x05.
  - After ovf_clr=1 for one cycle, overflow=0.
  - ovf_clr asserted in the same cycle as a drop leaves overflow=1.
- **Enable gating:** push 0x3C and 0xC3, then deassert enable during bit 3 of the first byte.
  - 0x3C completes and the block goes IDLE, with 0xC3 still held.
  - Reasserting enable starts 0xC3 on the next edge.
- **HALF_PERIOD=1 corner:** push 0x80.
  - ssp_clk toggles every cycle.
  - ssp_din=1 for 2 cycles, then 0 for 14.
  - Total busy time is 16 cycles.
